alt_mem_ddrx_ecc_decoder_mlane: RTL

ALT_MEM_DDRX_ECC_DECODER_MLANE -- requirements
Module: alt_mem_ddrx_ecc_decoder_mlane

---
 rtl/alt_mem_ddrx_ecc_pkg.sv | 52 +++++
 rtl/alt_mem_ddrx_ecc_dec_lane.sv | 33 +++
 rtl/alt_mem_ddrx_ecc_decoder_mlane.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/alt_mem_ddrx_ecc_pkg.sv
// Shared SECDED definitions for the DDRx ECC datapath.
//   - Lane geometry: 72-bit codeword = {ECC[7:0], DATA[63:0]}.
//   - H_MATRIX: one 8-bit check column per data bit, shared with the 64-bit
//     encoder. Data columns are the first 64 odd-weight (>=3) byte values in
//     ascending order. Check bit j uses the weight-1 column (1 << j).
//   - calc_ecc(): check bits for a 64-bit data word.
//   - scrub_state_e: encoding of the scrub request FSM states.
package alt_mem_ddrx_ecc_pkg;

    localparam int ECC_LANE_W = 72;
    localparam int ECC_DATA_W = 64;
    localparam int ECC_CHK_W  = 8;

    typedef enum logic {
        SCRUB_IDLE = 1'b0,
        SCRUB_REQ  = 1'b1
    } scrub_state_e;

    typedef logic [ECC_DATA_W-1:0][ECC_CHK_W-1:0] h_matrix_t;

    // All columns are distinct and of odd weight, and none has weight 1.
    // Therefore any single-bit error gives an odd syndrome, and any
    // double-bit error gives an even, nonzero syndrome.
    function automatic h_matrix_t gen_h_matrix();
        h_matrix_t h;
        int        n;
        int        w;
        h = '0;
        n = 0;
        for (int v = 1; v < 256; v++) begin
            w = 0;
            for (int b = 0; b < 8; b++) w += (v >> b) & 1;
            if (w >= 3 && (w % 2) == 1 && n < ECC_DATA_W) begin
                h[n] = v[ECC_CHK_W-1:0];
                n++;
            end
        end
        return h;
    endfunction

    localparam h_matrix_t H_MATRIX = gen_h_matrix();

    function automatic logic [ECC_CHK_W-1:0] calc_ecc(input logic [ECC_DATA_W-1:0] d);
        logic [ECC_CHK_W-1:0] e;
        e = '0;
        for (int i = 0; i < ECC_DATA_W; i++) begin
            if (d[i]) e ^= H_MATRIX[i];
        end
        return e;
    endfunction

endpackage

// File: rtl/alt_mem_ddrx_ecc_dec_lane.sv
// Combinational SECDED decoder for a single 72-bit lane.
//   lane_i : {ECC[7:0], DATA[63:0]} as received
//   data_o : data, corrected when a single-bit error is found in the data bits
//   sbe_o  : single-bit error (in either data or check bits), corrected
//   dbe_o  : uncorrectable error; data_o carries the received data unchanged
module alt_mem_ddrx_ecc_dec_lane
    import alt_mem_ddrx_ecc_pkg::*;
(
    input  logic [ECC_LANE_W-1:0] lane_i,
    output logic [ECC_DATA_W-1:0] data_o,
    output logic                  sbe_o,
    output logic                  dbe_o
);

    logic [ECC_CHK_W-1:0]  syn;
    logic [ECC_DATA_W-1:0] flip;

    assign syn = lane_i[ECC_LANE_W-1:ECC_DATA_W] ^ calc_ecc(lane_i[ECC_DATA_W-1:0]);

    // At most one column can match, because all columns are distinct.
    // An even-weight syndrome can never match, because all columns are odd.
    always_comb begin
        for (int i = 0; i < ECC_DATA_W; i++) flip[i] = (H_MATRIX[i] == syn);
    end

    // An odd-weight syndrome is a single-bit error only when it names a data
    // column or a check bit. An odd syndrome that names neither is treated as
    // uncorrectable.
    assign sbe_o  = (^syn) && ((|flip) || $onehot(syn));
    assign dbe_o  = (syn != '0) && !sbe_o;
    assign data_o = lane_i[ECC_DATA_W-1:0] ^ (sbe_o ? flip : '0);

endmodule

// File: rtl/alt_mem_ddrx_ecc_decoder_mlane.sv
// Multi-lane SECDED read-data decoder with error accounting.
//   ctl_clk / ctl_reset_n      : clock, asynchronous active-low reset
//   cfg_enable_ecc             : 1 = decode, 0 = bypass (same latency, no flags)
//   input_data/_valid/_addr    : read beat, CFG_ECC_LANES x {ECC 8, data 64}
//   output_data/_valid/_addr   : decoded beat, 1+CFG_ECC_DEC_REG cycles later
//   err_sbe_lane/err_dbe_lane  : per-lane flags, qualified by output_data_valid
//   err_corrected / err_fatal  : beat summary flags
//   sbe_count/dbe_count        : saturating lane-error counters, cnt_clear zeroes
//   err_log_*                  : first-error capture with fatal upgrade
//   scrub_req/addr/ack/drop    : one outstanding scrub request for corrected beats
module alt_mem_ddrx_ecc_decoder_mlane
    import alt_mem_ddrx_ecc_pkg::*;
#(
    parameter int CFG_ECC_LANES     = 2,
    parameter int CFG_ECC_DEC_REG   = 1,
    parameter int CFG_ADDR_WIDTH    = 32,
    parameter int CFG_ERR_CNT_WIDTH = 16
) (
    input  logic                                 ctl_clk,
    input  logic                                 ctl_reset_n,
    input  logic                                 cfg_enable_ecc,
    input  logic [ECC_LANE_W*CFG_ECC_LANES-1:0]  input_data,
    input  logic                                 input_data_valid,
    input  logic [CFG_ADDR_WIDTH-1:0]            input_addr,
    output logic [ECC_DATA_W*CFG_ECC_LANES-1:0]  output_data,
    output logic                                 output_data_valid,
    output logic [CFG_ADDR_WIDTH-1:0]            output_addr,
    output logic [CFG_ECC_LANES-1:0]             err_sbe_lane,
    output logic [CFG_ECC_LANES-1:0]             err_dbe_lane,
    output logic                                 err_corrected,
    output logic                                 err_fatal,
    output logic [CFG_ERR_CNT_WIDTH-1:0]         sbe_count,
    output logic [CFG_ERR_CNT_WIDTH-1:0]         dbe_count,
    input  logic                                 cnt_clear,
    output logic                                 err_log_valid,
    output logic [CFG_ADDR_WIDTH-1:0]            err_log_addr,
    output logic                                 err_log_fatal,
    input  logic                                 err_log_clear,
    output logic                                 scrub_req,
    output logic [CFG_ADDR_WIDTH-1:0]            scrub_addr,
    input  logic                                 scrub_ack,
    output logic                                 scrub_drop
);

    localparam int L  = CFG_ECC_LANES;
    localparam int AW = CFG_ADDR_WIDTH;
    localparam int CW = CFG_ERR_CNT_WIDTH;
    localparam int SW = CW + 4;  // headroom for adding up to 8 lane errors

    // Input stage: registered every cycle. The enable travels with the beat.
    logic                    s1_vld_q, s1_en_q;
    logic [AW-1:0]           s1_addr_q;
    logic [ECC_LANE_W*L-1:0] s1_data_q;

    always_ff @(posedge ctl_clk or negedge ctl_reset_n) begin
        if (!ctl_reset_n) begin
            s1_vld_q  <= 1'b0;
            s1_en_q   <= 1'b0;
            s1_addr_q <= '0;
            s1_data_q <= '0;
        end else begin
            s1_vld_q  <= input_data_valid;
            s1_en_q   <= cfg_enable_ecc;
            s1_addr_q <= input_addr;
            s1_data_q <= input_data;
        end
    end

    logic [L-1:0][ECC_DATA_W-1:0] dec_data, r1_data;
    logic [L-1:0]                 dec_sbe, dec_dbe, r1_sbe, r1_dbe;

    for (genvar l = 0; l < L; l++) begin : g_lane
        alt_mem_ddrx_ecc_dec_lane u_lane (
            .lane_i (s1_data_q[l*ECC_LANE_W +: ECC_LANE_W]),
            .data_o (dec_data[l]),
            .sbe_o  (dec_sbe[l]),
            .dbe_o  (dec_dbe[l])
        );
        assign r1_data[l] = s1_en_q ? dec_data[l] : s1_data_q[l*ECC_LANE_W +: ECC_DATA_W];
    end

    // Flags are gated here, so they are never visible without a valid beat.
    assign r1_sbe = (s1_vld_q && s1_en_q) ? dec_sbe : '0;
    assign r1_dbe = (s1_vld_q && s1_en_q) ? dec_dbe : '0;

    logic                         out_vld;
    logic [AW-1:0]                out_addr;
    logic [L-1:0][ECC_DATA_W-1:0] out_data;
    logic [L-1:0]                 out_sbe, out_dbe;

    if (CFG_ECC_DEC_REG != 0) begin : g_reg
        logic                         s2_vld_q;
        logic [AW-1:0]                s2_addr_q;
        logic [L-1:0][ECC_DATA_W-1:0] s2_data_q;
        logic [L-1:0]                 s2_sbe_q, s2_dbe_q;

        always_ff @(posedge ctl_clk or negedge ctl_reset_n) begin
            if (!ctl_reset_n) begin
                s2_vld_q  <= 1'b0;
                s2_addr_q <= '0;
                s2_data_q <= '0;
                s2_sbe_q  <= '0;
                s2_dbe_q  <= '0;
            end else begin
                s2_vld_q  <= s1_vld_q;
                s2_addr_q <= s1_addr_q;
                s2_data_q <= r1_data;
                s2_sbe_q  <= r1_sbe;
                s2_dbe_q  <= r1_dbe;
            end
        end
        assign out_vld  = s2_vld_q;
        assign out_addr = s2_addr_q;
        assign out_data = s2_data_q;
        assign out_sbe  = s2_sbe_q;
        assign out_dbe  = s2_dbe_q;
    end else begin : g_noreg
        assign out_vld  = s1_vld_q;
        assign out_addr = s1_addr_q;
        assign out_data = r1_data;
        assign out_sbe  = r1_sbe;
        assign out_dbe  = r1_dbe;
    end

    assign output_data_valid = out_vld;
    assign output_addr       = out_addr;
    assign output_data       = out_data;
    assign err_sbe_lane      = out_sbe;
    assign err_dbe_lane      = out_dbe;
    assign err_fatal         = |out_dbe;
    assign err_corrected     = (|out_sbe) && !err_fatal;

    // Counters, error log and scrub FSM all observe the output beat.
    logic [CW-1:0] sbe_cnt_q, sbe_cnt_d, dbe_cnt_q, dbe_cnt_d;
    logic [SW-1:0] sbe_sum, dbe_sum;
    logic          log_vld_q, log_vld_d, log_fatal_q, log_fatal_d;
    logic [AW-1:0] log_addr_q, log_addr_d, scrub_addr_q, scrub_addr_d;
    scrub_state_e  state_q, state_d;

    always_comb begin
        sbe_sum   = SW'(sbe_cnt_q) + SW'($countones(out_sbe));
        dbe_sum   = SW'(dbe_cnt_q) + SW'($countones(out_dbe));
        sbe_cnt_d = sbe_cnt_q;
        dbe_cnt_d = dbe_cnt_q;
        if (cnt_clear) begin
            sbe_cnt_d = '0;
            dbe_cnt_d = '0;
        end else if (out_vld) begin
            sbe_cnt_d = (sbe_sum > SW'({CW{1'b1}})) ? '1 : sbe_sum[CW-1:0];
            dbe_cnt_d = (dbe_sum > SW'({CW{1'b1}})) ? '1 : dbe_sum[CW-1:0];
        end
    end

    // If a new error arrives in the same cycle as a log clear, the new error
    // is captured. A fatal error replaces a logged correctable entry.
    always_comb begin
        log_vld_d   = log_vld_q;
        log_fatal_d = log_fatal_q;
        log_addr_d  = log_addr_q;
        if ((err_corrected || err_fatal) &&
            (!log_vld_q || err_log_clear || (!log_fatal_q && err_fatal))) begin
            log_vld_d   = 1'b1;
            log_fatal_d = err_fatal;
            log_addr_d  = out_addr;
        end else if (err_log_clear) begin
            log_vld_d = 1'b0;
        end
    end

    always_comb begin
        state_d      = state_q;
        scrub_addr_d = scrub_addr_q;
        scrub_drop   = 1'b0;
        case (state_q)
            SCRUB_IDLE: begin
                if (err_corrected) begin
                    state_d      = SCRUB_REQ;
                    scrub_addr_d = out_addr;
                end
            end
            SCRUB_REQ: begin
                // While a request is outstanding, including the ack cycle,
                // a newly corrected beat is dropped.
                scrub_drop = err_corrected;
                if (scrub_ack) state_d = SCRUB_IDLE;
            end
            default: state_d = SCRUB_IDLE;
        endcase
    end

    always_ff @(posedge ctl_clk or negedge ctl_reset_n) begin
        if (!ctl_reset_n) begin
            sbe_cnt_q    <= '0;
            dbe_cnt_q    <= '0;
            log_vld_q    <= 1'b0;
            log_fatal_q  <= 1'b0;
            log_addr_q   <= '0;
            scrub_addr_q <= '0;
            state_q      <= SCRUB_IDLE;
        end else begin
            sbe_cnt_q    <= sbe_cnt_d;
            dbe_cnt_q    <= dbe_cnt_d;
            log_vld_q    <= log_vld_d;
            log_fatal_q  <= log_fatal_d;
            log_addr_q   <= log_addr_d;
            scrub_addr_q <= scrub_addr_d;
            state_q      <= state_d;
        end
    end

    assign sbe_count     = sbe_cnt_q;
    assign dbe_count     = dbe_cnt_q;
    assign err_log_valid = log_vld_q;
    assign err_log_fatal = log_fatal_q;
    assign err_log_addr  = log_addr_q;
    assign scrub_req     = (state_q == SCRUB_REQ);
    assign scrub_addr    = scrub_addr_q;

endmodule
